// File: rtl/alu_pkg.sv
// Shared constants for the handshaked multi-cycle ALU: opcodes, flag bit
// positions and FSM state encoding.
package alu_pkg;

  localparam logic [7:0] OP_ADD  = 8'd0;
  localparam logic [7:0] OP_SUB  = 8'd1;
  localparam logic [7:0] OP_MUL  = 8'd2;
  localparam logic [7:0] OP_DIV  = 8'd3;
  localparam logic [7:0] OP_SLL  = 8'd4;
  localparam logic [7:0] OP_SRL  = 8'd5;
  localparam logic [7:0] OP_AND  = 8'd6;
  localparam logic [7:0] OP_OR   = 8'd7;
  localparam logic [7:0] OP_XOR  = 8'd8;
  localparam logic [7:0] OP_SRA  = 8'd9;
  localparam logic [7:0] OP_REM  = 8'd10;
  localparam logic [7:0] OP_SLTU = 8'd11;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_DBZ   = 3;
  localparam int FLG_ILL   = 4;
  localparam int NFLAGS    = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// quotient/remainder show the outcome of the current step; they are final
// in the cycle where done is high.
module alu_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  // quo_q doubles as the dividend shift register: its MSB feeds the
  // partial remainder while quotient bits enter at the LSB.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dsr_q};
    fits   = (rem_sh >= {1'b0, dsr_q});
    rem_nx = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx = {quo_q[WIDTH-2:0], fits};
  end

  assign done      = busy && (cnt == '0);
  assign quotient  = quo_nx;
  assign remainder = rem_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      cnt   <= CW'(WIDTH - 1);
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
      busy  <= 1'b1;
    end else if (busy) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Handshaked ALU: single-cycle ops register on the accept edge, DIV/REM run
// through the iterative divider. Results are held until the consumer takes them.
// valid/ready: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds its payload stable while valid is high and not taken.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  logic [1:0]        state;
  logic [WIDTH-1:0]  result_q;
  logic [NFLAGS-1:0] flags_q;
  logic              is_rem_q;

  logic              accept;
  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [WIDTH-1:0]  div_quo;
  logic [WIDTH-1:0]  div_rem;
  logic [WIDTH-1:0]  div_res;

  logic [WIDTH:0]    add_w;
  logic [WIDTH-1:0]  sub_w;
  logic [WIDTH-1:0]  mul_w;
  logic [SHW-1:0]    sh;
  logic [WIDTH-1:0]  res_c;
  logic [NFLAGS-1:0] flg_c;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign result    = result_q;
  assign flags     = flags_q;

  assign accept    = in_valid && in_ready;
  assign div_start = accept && (opcode == OP_DIV || opcode == OP_REM) && (operand2 != '0);
  assign div_res   = is_rem_q ? div_rem : div_quo;

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (operand1),
    .divisor   (operand2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    add_w = {1'b0, operand1} + {1'b0, operand2};
    sub_w = operand1 - operand2;
    mul_w = operand1 * operand2;
    sh    = operand2[SHW-1:0];
    res_c = '0;
    flg_c = '0;
    case (opcode)
      OP_ADD: begin
        res_c            = add_w[WIDTH-1:0];
        flg_c[FLG_CARRY] = add_w[WIDTH];
        flg_c[FLG_OVF]   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                           (add_w[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SUB: begin
        res_c            = sub_w;
        flg_c[FLG_CARRY] = (operand1 < operand2);
        flg_c[FLG_OVF]   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                           (sub_w[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_MUL:  res_c = mul_w;
      // Only the divide-by-zero case reaches here; nonzero divisors go to the divider.
      OP_DIV: begin
        res_c          = '1;
        flg_c[FLG_DBZ] = 1'b1;
      end
      OP_REM: begin
        res_c          = operand1;
        flg_c[FLG_DBZ] = 1'b1;
      end
      OP_SLL:  res_c = operand1 << sh;
      OP_SRL:  res_c = operand1 >> sh;
      OP_SRA:  res_c = WIDTH'($signed(operand1) >>> sh);
      OP_AND:  res_c = operand1 & operand2;
      OP_OR:   res_c = operand1 | operand2;
      OP_XOR:  res_c = operand1 ^ operand2;
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
      default: flg_c[FLG_ILL] = 1'b1;
    endcase
    flg_c[FLG_ZERO] = (res_c == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      is_rem_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (div_start) begin
            state    <= ST_DIV;
            is_rem_q <= (opcode == OP_REM);
          end else if (accept) begin
            state    <= ST_DONE;
            result_q <= res_c;
            flags_q  <= flg_c;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            state             <= ST_DONE;
            result_q          <= div_res;
            flags_q           <= '0;
            flags_q[FLG_ZERO] <= (div_res == '0);
          end else if (!div_busy) begin
            state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, corner-case sequences
// and randomized operations checked against an arithmetic reference model.
module tb_alu_mc;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   opcode;
  logic [W-1:0] operand1;
  logic [W-1:0] operand2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;

  int n_checks;
  int n_pass;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [4:0]   f;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  // Reference model: flags packed {illegal, div_by_zero, overflow, carry, zero}.
  function automatic void model(input logic [7:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic [4:0] f, output int lat);
    logic [W+1:0]        wide;
    logic signed [W+1:0] sa, sb, ss, smax, smin;
    int unsigned         sh;
    sh   = int'(b % W);
    sa   = $signed({{2{a[W-1]}}, a});
    sb   = $signed({{2{b[W-1]}}, b});
    smax = $signed({3'b000, {(W-1){1'b1}}});
    smin = -smax - 1;
    r    = '0;
    f    = '0;
    lat  = 0;
    case (op)
      8'd0: begin
        wide = {2'b00, a} + {2'b00, b};
        r    = wide[W-1:0];
        f[1] = wide[W];
        ss   = sa + sb;
        f[2] = (ss > smax) || (ss < smin);
      end
      8'd1: begin
        r    = a - b;
        f[1] = (a < b);
        ss   = sa - sb;
        f[2] = (ss > smax) || (ss < smin);
      end
      8'd2: r = a * b;
      8'd3: begin
        if (b == 0) begin r = '1; f[3] = 1'b1; end
        else begin r = a / b; lat = W; end
      end
      8'd10: begin
        if (b == 0) begin r = a; f[3] = 1'b1; end
        else begin r = a % b; lat = W; end
      end
      8'd4: r = a << sh;
      8'd5: r = a >> sh;
      8'd9: begin
        r = a >> sh;
        if (a[W-1]) r = r | ~({W{1'b1}} >> sh);
      end
      8'd6: r = a & b;
      8'd7: r = a | b;
      8'd8: r = a ^ b;
      8'd11: r = (a < b) ? 1 : 0;
      default: f[4] = 1'b1;
    endcase
    f[0] = (r == 0);
  endfunction

  // Driver: issue one op, scramble inputs after accept, wait for the result,
  // then consume it. Returns the result, flags and edges from accept to out_valid.
  task automatic do_op(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic [4:0] flg, output int lat);
    int g;
    logic rdy_seen;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("in_ready_before_issue", W'(in_ready), W'(1));
    opcode   = op;
    operand1 = a;
    operand2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    opcode   = 8'($urandom);
    operand1 = {$urandom(), $urandom()};
    operand2 = {$urandom(), $urandom()};
    lat      = 0;
    rdy_seen = in_ready;
    while (!out_valid && lat < W + 20) begin
      @(posedge clk);
      #1;
      lat++;
      rdy_seen = rdy_seen | in_ready;
    end
    chk("in_ready_low_while_busy", W'(rdy_seen), W'(0));
    res = result;
    flg = flags;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_consume", W'(out_valid), W'(0));
    chk("in_ready_after_consume", W'(in_ready), W'(1));
  endtask

  task automatic run_checked(input string tag, input logic [7:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] er, input logic [4:0] ef, input int elat);
    logic [W-1:0] r;
    logic [4:0]   f;
    int           lat;
    do_op(op, a, b, r, f, lat);
    chk({tag, "_result"}, r, er);
    chk({tag, "_flags"}, W'(f), W'(ef));
    chk({tag, "_latency"}, W'(lat), W'(elat));
  endtask

  initial begin
    logic [W-1:0] mr;
    logic [4:0]   mf;
    int           ml;
    logic [7:0]   op;
    logic [W-1:0] a, b;

    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = '0;
    operand1  = '0;
    operand2  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_result", result, '0);
    chk("reset_flags", W'(flags), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // op, a, b, expected result, expected flags, expected latency
    vecs.push_back('{8'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 5'b00011, 0});
    vecs.push_back('{8'd1,  64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h8000_0000_0000_0000, 5'b00110, 0});
    vecs.push_back('{8'd0,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 5'b00100, 0});
    vecs.push_back('{8'd3,  64'd100, 64'd7, 64'd14, 5'b00000, 64});
    vecs.push_back('{8'd10, 64'd100, 64'd7, 64'd2,  5'b00000, 64});
    vecs.push_back('{8'd3,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'b01000, 0});
    vecs.push_back('{8'd10, 64'd5, 64'd0, 64'd5, 5'b01000, 0});
    vecs.push_back('{8'd9,  64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 5'b00000, 0});
    vecs.push_back('{8'h20, 64'd123, 64'd456, 64'd0, 5'b10001, 0});
    vecs.push_back('{8'd2,  64'h1_0000_0000, 64'h1_0000_0001, 64'h1_0000_0000, 5'b00000, 0});
    vecs.push_back('{8'd11, 64'd3, 64'd5, 64'd1, 5'b00000, 0});
    vecs.push_back('{8'd11, 64'd5, 64'd3, 64'd0, 5'b00001, 0});
    vecs.push_back('{8'd4,  64'd1, 64'd63, 64'h8000_0000_0000_0000, 5'b00000, 0});
    vecs.push_back('{8'd5,  64'h8000_0000_0000_0000, 64'h40, 64'h8000_0000_0000_0000, 5'b00000, 0});
    vecs.push_back('{8'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'b00000, 64});
    vecs.push_back('{8'd10, 64'd0, 64'd3, 64'd0, 5'b00001, 64});
    vecs.push_back('{8'd8,  64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234, 64'd0, 5'b00001, 0});
    vecs.push_back('{8'd6,  64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0,
                     64'h00F0_00F0_00F0_00F0, 5'b00000, 0});
    vecs.push_back('{8'd7,  64'hF000_0000_0000_0000, 64'h0000_0000_0000_000F,
                     64'hF000_0000_0000_000F, 5'b00000, 0});

    foreach (vecs[i])
      run_checked($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].r, vecs[i].f, vecs[i].lat);

    // Back-pressure: result must stay put while out_ready is low.
    @(negedge clk);
    opcode   = 8'd0;
    operand1 = 64'd40;
    operand2 = 64'd2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    operand1 = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", W'(out_valid), W'(1));
      chk("bp_in_ready", W'(in_ready), W'(0));
      chk("bp_result", result, 64'd42);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_released_in_ready", W'(in_ready), W'(1));

    // Reset during a division aborts it.
    @(negedge clk);
    opcode   = 8'd3;
    operand1 = 64'd1000;
    operand2 = 64'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", W'(out_valid), W'(0));
    chk("abort_in_ready", W'(in_ready), W'(1));
    chk("abort_result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 5) @(posedge clk);
    #1;
    chk("abort_no_late_result", W'(out_valid), W'(0));
    run_checked("after_abort_add", 8'd0, 64'd2, 64'd3, 64'd5, 5'b00000, 0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      op = 8'($urandom_range(0, 13));
      a  = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 300));
        3:       b = a;
        default: b = {$urandom(), $urandom()};
      endcase
      if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 5000));
      model(op, a, b, mr, mf, ml);
      run_checked($sformatf("rnd%0d_op%0d", i, op), op, a, b, mr, mf, ml);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, handshaked successor of the single-cycle 64-bit ALU.
- Adds valid/ready flow control on input and output, and an iterative restoring divider (DIV/REM).
- Adds arithmetic right shift, unsigned set-less-than, and status flags.
- Sits between the issue stage and the writeback stage. It accepts one operation at a time and holds each result until the consumer takes it.

Parameters:
- WIDTH, 64, operand/result width in bits; WIDTH ≥ 8, power of two.
- SHW, $clog2(WIDTH), shift-amount bits taken from operand2 (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an operation
- opcode  in  8  operation code
- operand1  in  WIDTH  operand A
- operand2  in  WIDTH  operand B
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  operation result
- flags  out  5  {illegal, div_by_zero, overflow, carry, zero}

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; result=0; flags=0; out_valid=0; in_ready=1; divider counter=0.
  - Reset asserted mid-division aborts the operation; no result is produced.
- Opcodes (in alu_pkg):
  - ADD=0, SUB=1, MUL=2, DIV=3, SLL=4, SRL=5, AND=6, OR=7, XOR=8, SRA=9, REM=10, SLTU=11.
  - Codes 0–8 keep the previous ALU's encoding.
- Handshake:
  - An operation is accepted on a rising edge where in_valid && in_ready.
  - in_ready = (state==IDLE).
  - The result is consumed on an edge where out_valid && out_ready.
- State machine IDLE / DIV / DONE:
  - IDLE, accept, opcode DIV/REM with operand2≠0 → DIV: latch operands, counter=WIDTH-1.
  - IDLE, accept, any other opcode (including DIV/REM with operand2=0) → DONE. result and flags are registered on the accept edge.
  - DIV: one quotient bit per edge. On the edge where counter==0, load result and flags → DONE.
  - DONE: out_valid=1. result and flags are held stable until out_ready=1, then → IDLE.
  - No new accept is possible in the cycle the result is consumed; in_ready rises the cycle after.
- Latency, counted from the accept edge:
  - Single-cycle ops: out_valid high in the following cycle.
  - DIV/REM (operand2≠0): out_valid high after WIDTH further edges.
  - Inputs are sampled only at accept; later changes on operand1/operand2/opcode do not affect the operation in flight.
- Arithmetic (all unsigned unless stated; results truncated to WIDTH):
  - MUL returns the low WIDTH bits of the product.
  - SLL/SRL/SRA shift by operand2[SHW-1:0]. SRA replicates operand1[WIDTH-1].
  - SLTU: result = (operand1 < operand2) ? 1 : 0.
  - DIV returns the quotient; REM returns the remainder.
  - operand2=0 on DIV: result = all ones. On REM: result = operand1. Both set div_by_zero.
- Flags:
  - zero = (result==0), for every opcode.
  - carry: ADD carry-out; SUB borrow (operand1<operand2); 0 otherwise.
  - overflow: signed two's-complement overflow for ADD/SUB; 0 otherwise.
  - illegal: opcode > 11; result=0, zero=1, all other flags 0.
- Back-pressure: DONE may be held indefinitely; out_valid stays asserted and result stays unchanged.

Decomposition:
- alu_pkg holds:
  - opcode localparams (OP_ADD..OP_SLTU)
  - flag bit indices (FLG_ZERO=0, FLG_CARRY=1, FLG_OVF=2, FLG_DBZ=3, FLG_ILL=4)
  - state encoding
- Sub-module alu_divider:
  - iterative restoring unsigned divider
  - start/busy/done ports; outputs quotient and remainder
  - WIDTH parameter shared with alu_mc
- Top level holds the FSM, the single-cycle datapath, and the flag logic.

Test Plan:
- WIDTH=64, ADD 0xFFFF_FFFF_FFFF_FFFF + 1, out_ready=1 → out_valid one cycle after accept; result=0; flags zero=1, carry=1, overflow=0.
- SUB 0x7FFF_FFFF_FFFF_FFFF - 0xFFFF_FFFF_FFFF_FFFF → result=0x8000_0000_0000_0000; overflow=1, carry(borrow)=1.
- DIV 100 / 7, then REM 100 / 7 → results 14 and 2; out_valid exactly 64 edges after the accept edge; in_ready=0 throughout.
- DIV 5 / 0 and REM 5 / 0 → immediate DONE; results 0xFFFF_FFFF_FFFF_FFFF and 5; div_by_zero=1.
- SRA 0x8000_0000_0000_0000 by operand2=0x43 (shift 3) → 0xF000_0000_0000_0000. Opcode 0x20 → result=0, illegal=1, zero=1.
- Back-pressure: out_ready=0 for 10 cycles after an ADD → result stable, in_ready=0. Assert rst_n=0 at iteration 30 of a DIV → out_valid=0 and in_ready=1 immediately; a following ADD 2+3 gives 5.
